mem_port_arbiter: RTL and testbench

//  Shares the single cache port (2-way, 4-set cache; addr/write_data/write_en/func3 in,

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_timer.sv | 37 +++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//  state_e : arbiter sequencing states (idle, access in flight, done pulse)
//  owner_e : which pipeline stage owns the access in flight
//  Func3*  : cache access size encodings
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } state_e;

  typedef enum logic {
    OwnI,
    OwnD
  } owner_e;

  localparam logic [2:0] Func3Byte = 3'b000;
  localparam logic [2:0] Func3Half = 3'b001;
  localparam logic [2:0] Func3Word = 3'b010;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait counter for one cache access.
//  clk         in  clock
//  reset       in  synchronous active-high reset
//  clr         in  force count to zero
//  en          in  count one cycle (saturates at TIMEOUT)
//  min_reached out count >= MIN_WAIT
//  timed_out   out count == TIMEOUT
module mem_arb_timer #(
  parameter int unsigned MIN_WAIT = 2,
  parameter int unsigned TIMEOUT  = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic min_reached,
  output logic timed_out
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntMin = CntW'(MIN_WAIT);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (en && (count_q != CntMax)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign min_reached = (count_q >= CntMin);
  assign timed_out   = (count_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single cache port between instruction fetch and load/store.
// Data wins by default; after MAX_D_STREAK consecutive data grants with a fetch
// pending, fetch is granted. Each access is held for at least MIN_WAIT cycles and
// completes on ~c_busy & (c_hit | store); TIMEOUT cycles without completion sets
// the sticky err and finishes the access with zero read data.
//  clk, reset                         clock, synchronous active-high reset
//  i_req/i_addr -> i_rdata/i_done     fetch side
//  d_req/d_we/d_addr/d_wdata/d_func3 -> d_rdata/d_done   load/store side
//  c_addr/c_wdata/c_we/c_func3 -> cache, c_rdata/c_hit/c_busy <- cache
//  stall_if, stall_mem                per-stage stalls (combinational)
//  err                                sticky timeout flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned MIN_WAIT     = 2,
  parameter int unsigned TIMEOUT      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] c_addr,
  output logic [31:0] c_wdata,
  output logic        c_we,
  output logic [2:0]  c_func3,
  input  logic [31:0] c_rdata,
  input  logic        c_hit,
  input  logic        c_busy,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam int unsigned StreakW = $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [31:0] c_addr_q, c_addr_d, c_wdata_q, c_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic        c_we_q, c_we_d, i_done_q, i_done_d, d_done_q, d_done_d, err_q, err_d;
  logic [2:0]  c_func3_q, c_func3_d;
  logic        min_reached, timed_out, complete;
  logic [31:0] rdata_sel;

  // Counter idles at zero so a grant always starts from a cleared count.
  mem_arb_timer #(
    .MIN_WAIT (MIN_WAIT),
    .TIMEOUT  (TIMEOUT)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .clr         (state_q == StIdle),
    .en          (state_q == StIssue),
    .min_reached (min_reached),
    .timed_out   (timed_out)
  );

  // Stores do not need a hit; loads wait for the fill.
  assign complete  = min_reached && !c_busy && (c_hit || c_we_q);
  assign rdata_sel = complete ? c_rdata : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    streak_d  = streak_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_we_d    = c_we_q;
    c_func3_d = c_func3_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_req && (!d_req || (streak_q == StreakMax))) begin
          state_d   = StIssue;
          owner_d   = OwnI;
          c_addr_d  = i_addr;
          c_wdata_d = '0;
          c_we_d    = 1'b0;
          c_func3_d = Func3Word;
          streak_d  = '0;
        end else if (d_req) begin
          state_d   = StIssue;
          owner_d   = OwnD;
          c_addr_d  = d_addr;
          c_wdata_d = d_wdata;
          c_we_d    = d_we;
          c_func3_d = d_func3;
          // Streak only counts grants that actually made a fetch wait.
          if (!i_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
          end
        end else begin
          c_we_d = 1'b0;
        end
      end
      StIssue: begin
        if (complete || timed_out) begin
          if (!complete) begin
            err_d = 1'b1;
          end
          if (owner_q == OwnI) begin
            i_rdata_d = rdata_sel;
            i_done_d  = 1'b1;
          end else begin
            d_rdata_d = rdata_sel;
            d_done_d  = 1'b1;
          end
          c_we_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      owner_q   <= OwnI;
      streak_q  <= '0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      c_we_q    <= 1'b0;
      c_func3_q <= Func3Word;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      c_we_q    <= c_we_d;
      c_func3_q <= c_func3_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
    end
  end

  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign c_we      = c_we_q;
  assign c_func3   = c_func3_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign err       = err_q;
  assign stall_if  = i_req & ~i_done_q;
  assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a transaction-level reference model
// is compared against the DUT every cycle, and directed scenarios pin latencies
// and values that were worked out by hand.
module tb_mem_port_arbiter;

  localparam int MaxDStreak = 4;
  localparam int MinWait    = 2;
  localparam int Timeout    = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, c_hit, c_busy;
  logic [31:0] i_addr, d_addr, d_wdata, c_rdata;
  logic [2:0]  d_func3;
  logic [31:0] i_rdata, d_rdata, c_addr, c_wdata;
  logic        i_done, d_done, c_we, stall_if, stall_mem, err;
  logic [2:0]  c_func3;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .MAX_D_STREAK (MaxDStreak),
    .MIN_WAIT     (MinWait),
    .TIMEOUT      (Timeout)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_func3   (d_func3),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_we      (c_we),
    .c_func3   (c_func3),
    .c_rdata   (c_rdata),
    .c_hit     (c_hit),
    .c_busy    (c_busy),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access record plus its age in cycles since grant.
  bit          m_valid = 0;
  int          m_phase;   // 0 no access, 1 access in flight, 2 done cycle
  int          m_age;
  bit          m_own_d;
  int          m_streak;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  logic [2:0]  m_func3;
  bit          m_we, m_idone, m_ddone, m_err;

  task automatic model_finish(input logic [31:0] v);
    if (m_own_d) begin
      m_drdata = v;
      m_ddone  = 1;
    end else begin
      m_irdata = v;
      m_idone  = 1;
    end
    m_we    = 0;
    m_phase = 2;
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_age = 0; m_own_d = 0; m_streak = 0;
      m_addr = 0; m_wdata = 0; m_irdata = 0; m_drdata = 0;
      m_func3 = 3'b010; m_we = 0; m_idone = 0; m_ddone = 0; m_err = 0;
      return;
    end
    m_idone = 0;
    m_ddone = 0;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (m_age >= MinWait && !c_busy && (c_hit || m_we)) begin
        model_finish(c_rdata);
      end else if (m_age == Timeout) begin
        m_err = 1;
        model_finish(32'h0);
      end else begin
        m_age++;
      end
    end else if (i_req && (!d_req || m_streak == MaxDStreak)) begin
      m_phase = 1; m_age = 0; m_own_d = 0; m_streak = 0;
      m_addr = i_addr; m_wdata = 0; m_we = 0; m_func3 = 3'b010;
    end else if (d_req) begin
      m_phase = 1; m_age = 0; m_own_d = 1;
      m_streak = i_req ? ((m_streak < MaxDStreak) ? m_streak + 1 : MaxDStreak) : 0;
      m_addr = d_addr; m_wdata = d_wdata; m_we = d_we; m_func3 = d_func3;
    end else begin
      m_we = 0;
    end
  endtask

  initial begin : compare
    forever begin
      @(posedge clk);
      model_step();
      m_valid = 1;
      @(negedge clk);
      if (m_valid) begin
        chk("m_c_addr", c_addr, m_addr);
        chk("m_c_wdata", c_wdata, m_wdata);
        chk("m_c_we", c_we, m_we);
        chk("m_c_func3", c_func3, m_func3);
        chk("m_i_done", i_done, m_idone);
        chk("m_d_done", d_done, m_ddone);
        chk("m_i_rdata", i_rdata, m_irdata);
        chk("m_d_rdata", d_rdata, m_drdata);
        chk("m_err", err, m_err);
        chk("m_stall_if", stall_if, i_req & ~m_idone);
        chk("m_stall_mem", stall_mem, d_req & ~m_ddone);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Counts negedges until the selected done pulse; n=0 means it is already there.
  task automatic wait_done(input bit sel_d, input int max, output int n);
    bit seen;
    seen = 0;
    n = 0;
    while (!seen && n <= max) begin
      @(negedge clk);
      if (sel_d ? d_done : i_done) seen = 1;
      else n++;
    end
    chk(sel_d ? "wait_d_done" : "wait_i_done", seen, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int nd, ni;
    int dcnt [2];
    bit seen;
    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_func3 = 3'b010; c_rdata = 0; c_hit = 1; c_busy = 0;
    tick(2);
    @(negedge clk);
    chk("rst_c_func3", c_func3, 3'b010);
    chk("rst_c_addr", c_addr, 32'h0);
    chk("rst_c_we", c_we, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'h0);
    tick(1);
    reset = 0;
    tick(2);

    // Fetch only.
    c_rdata = 32'h0000_0013; i_addr = 32'h40; i_req = 1;
    wait_done(0, 10, n);
    chk("t1_latency", n, 4);
    chk("t1_i_rdata", i_rdata, 32'h0000_0013);
    tick(1);
    i_req = 0;
    @(negedge clk);
    chk("t1_stall_if_after", stall_if, 1'b0);
    tick(2);

    // Simultaneous requests: store wins, then fetch.
    d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'h1111_1111; d_func3 = 3'b010;
    i_req = 1; i_addr = 32'h44;
    @(negedge clk);
    @(negedge clk);
    chk("t2_c_we_issue", c_we, 1'b1);
    chk("t2_c_addr", c_addr, 32'h10);
    chk("t2_stall_if", stall_if, 1'b1);
    wait_done(1, 10, n);
    chk("t2_store_latency", n, 2);
    tick(1);
    d_req = 0; d_we = 0;
    wait_done(0, 10, n);
    chk("t2_fetch_latency", n, 4);
    chk("t2_i_rdata", i_rdata, 32'h0000_0013);
    tick(1);
    i_req = 0;
    tick(2);

    // Continuous data pressure with fetch pending: 4 data grants per fetch.
    i_addr = 32'h80; d_addr = 32'h20; d_we = 0; c_rdata = 32'h55;
    i_req = 1; d_req = 1;
    nd = 0; ni = 0; dcnt[0] = -1; dcnt[1] = -1;
    for (int c = 0; c < 80 && ni < 2; c++) begin
      @(negedge clk);
      if (d_done) nd++;
      if (i_done) begin
        dcnt[ni] = nd;
        nd = 0;
        ni++;
      end
    end
    chk("t3_fetch_rounds", ni, 2);
    chk("t3_data_grants_1", dcnt[0], 4);
    chk("t3_data_grants_2", dcnt[1], 4);
    tick(1);
    i_req = 0; d_req = 0;
    tick(2);

    // Load miss: busy for 6 cycles, then hit.
    c_busy = 1; c_hit = 0; c_rdata = 0;
    d_we = 0; d_addr = 32'h30; d_func3 = 3'b001; d_req = 1;
    tick(6);
    c_busy = 0; c_hit = 1; c_rdata = 32'hAAAA_0001;
    wait_done(1, 10, n);
    chk("t4_latency_after_fill", n, 1);
    chk("t4_d_rdata", d_rdata, 32'hAAAA_0001);
    tick(1);
    d_req = 0;
    @(negedge clk);
    chk("t4_single_pulse", d_done, 1'b0);
    tick(2);

    // Load that never hits: timeout.
    c_hit = 0; d_addr = 32'h34; d_func3 = 3'b010; d_req = 1;
    wait_done(1, 40, n);
    chk("t5_timeout_latency", n, 22);
    chk("t5_err", err, 1'b1);
    chk("t5_d_rdata", d_rdata, 32'h0);
    tick(1);
    d_req = 0; c_hit = 1;
    tick(3);
    @(negedge clk);
    chk("t5_err_sticky", err, 1'b1);
    tick(1);

    // Reset in the middle of a store.
    d_we = 1; d_addr = 32'h50; d_wdata = 32'hDEAD_0000; d_req = 1;
    tick(2);
    reset = 1;
    tick(1);
    reset = 0; d_req = 0; d_we = 0;
    @(negedge clk);
    chk("t6_c_we", c_we, 1'b0);
    chk("t6_err", err, 1'b0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (d_done || i_done) seen = 1;
    end
    chk("t6_no_done", seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
